// File: rtl/rf_wb_pkg.sv
// Shared types and widths for the register-file writeback arbiter.
package rf_wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Writeback request FIFO; registered storage, head visible the cycle after push.
// Caller gates push with !full and pop with !empty; per-entry rd/valid exposed for hazard compare.
module wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 push,
  input  wb_req_t                              push_dat,
  input  logic                                 pop,
  output logic                                 full,
  output logic                                 empty,
  output wb_req_t                              head,
  output logic [DEPTH-1:0]                     ent_vld,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]     ent_rd
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_req_t        mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;

  // Occupancy is carried by the per-entry valid bits; pointers wrap naturally at a power-of-2 depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ent_vld <= '0;
    end else begin
      if (push) begin
        ent_vld[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        ent_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_rd[i] = mem[i].rd;
  end

  assign full  = &ent_vld;
  assign empty = ~|ent_vld;
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-port writeback arbiter onto the single rf write port: A has priority, B ages to MAX_WAIT.
// One cycle push-to-write when uncontended; ready drops only while a port FIFO is full.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [REG_ADDR_W-1:0] a_rd,
  input  logic [XLEN-1:0]       a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [REG_ADDR_W-1:0] b_rd,
  input  logic [XLEN-1:0]       b_data,
  output logic                  rf_write_e,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]       rf_write_d,
  input  logic [REG_ADDR_W-1:0] chk_s1,
  input  logic [REG_ADDR_W-1:0] chk_s2,
  output logic                  hazard_s1,
  output logic                  hazard_s2,
  output logic                  busy
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  logic                              a_full, a_empty, b_full, b_empty;
  logic                              a_push, b_push, a_grant, b_grant, b_aged;
  wb_req_t                           a_head, b_head;
  logic [DEPTH-1:0]                  a_ent_vld, b_ent_vld;
  logic [DEPTH-1:0][REG_ADDR_W-1:0]  a_ent_rd, b_ent_rd;
  logic [WW-1:0]                     wait_cnt;

  assign a_ready = !rst && !a_full;
  assign b_ready = !rst && !b_full;

  // Writes to x0 still handshake but never occupy a slot.
  assign a_push = a_valid && a_ready && (a_rd != '0);
  assign b_push = b_valid && b_ready && (b_rd != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk      (clk),
    .rst      (rst),
    .push     (a_push),
    .push_dat ('{rd: a_rd, data: a_data}),
    .pop      (a_grant),
    .full     (a_full),
    .empty    (a_empty),
    .head     (a_head),
    .ent_vld  (a_ent_vld),
    .ent_rd   (a_ent_rd)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk      (clk),
    .rst      (rst),
    .push     (b_push),
    .push_dat ('{rd: b_rd, data: b_data}),
    .pop      (b_grant),
    .full     (b_full),
    .empty    (b_empty),
    .head     (b_head),
    .ent_vld  (b_ent_vld),
    .ent_rd   (b_ent_rd)
  );

  // Grants are suppressed during reset so queued entries are dropped rather than committed.
  assign b_aged  = (wait_cnt == WW'(MAX_WAIT));
  assign a_grant = !rst && !a_empty && !(!b_empty && b_aged);
  assign b_grant = !rst && !b_empty && (a_empty || b_aged);

  always_ff @(posedge clk) begin
    if (rst || b_empty || b_grant) wait_cnt <= '0;
    else if (!b_aged)              wait_cnt <= wait_cnt + 1'b1;
  end

  always_comb begin
    rf_write_e = a_grant || b_grant;
    rf_rd      = '0;
    rf_write_d = '0;
    if (a_grant) begin
      rf_rd      = a_head.rd;
      rf_write_d = a_head.data;
    end else if (b_grant) begin
      rf_rd      = b_head.rd;
      rf_write_d = b_head.data;
    end
  end

  always_comb begin
    hazard_s1 = 1'b0;
    hazard_s2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (a_ent_vld[i] && a_ent_rd[i] == chk_s1) hazard_s1 = 1'b1;
      if (b_ent_vld[i] && b_ent_rd[i] == chk_s1) hazard_s1 = 1'b1;
      if (a_ent_vld[i] && a_ent_rd[i] == chk_s2) hazard_s2 = 1'b1;
      if (b_ent_vld[i] && b_ent_rd[i] == chk_s2) hazard_s2 = 1'b1;
    end
    if (rst || chk_s1 == '0) hazard_s1 = 1'b0;
    if (rst || chk_s2 == '0) hazard_s2 = 1'b0;
  end

  assign busy = !rst && !(a_empty && b_empty);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomised scoreboard bench: queue-level model of both ports, grant/aging rules and hazards.
module tb_rf_wb_arbiter;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 3;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        a_ready, b_ready;
  logic [4:0]  a_rd = '0, b_rd = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        rf_write_e;
  logic [4:0]  rf_rd;
  logic [31:0] rf_write_d;
  logic [4:0]  chk_s1 = '0, chk_s2 = '0;
  logic        hazard_s1, hazard_s2, busy;

  int total = 0;
  int bad   = 0;
  int b_forced = 0;

  ent_t qa[$];
  ent_t qb[$];
  int   losses = 0;

  rf_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_rd       (a_rd),
    .a_data     (a_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_rd       (b_rd),
    .b_data     (b_data),
    .rf_write_e (rf_write_e),
    .rf_rd      (rf_rd),
    .rf_write_d (rf_write_d),
    .chk_s1     (chk_s1),
    .chk_s2     (chk_s2),
    .hazard_s1  (hazard_s1),
    .hazard_s2  (hazard_s2),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  function automatic bit pending(input logic [4:0] r);
    foreach (qa[i]) if (qa[i].rd == r) return 1'b1;
    foreach (qb[i]) if (qb[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: compares every cycle against the model state, then retires the expected winner.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_write_e", rf_write_e, 0);
        chk("rst_rf_rd", rf_rd, 0);
        chk("rst_write_d", rf_write_d, 0);
        chk("rst_hz1", hazard_s1, 0);
        chk("rst_hz2", hazard_s2, 0);
        chk("rst_busy", busy, 0);
        qa.delete();
        qb.delete();
        losses = 0;
      end else begin
        bit   ha, hb;
        int   win;
        ent_t e;
        ha  = qa.size() > 0;
        hb  = qb.size() > 0;
        win = 0;
        if (ha && !(hb && losses == MAX_WAIT)) win = 1;
        else if (hb) win = 2;
        e.rd = '0;
        e.data = '0;
        if (win == 1) e = qa[0];
        if (win == 2) e = qb[0];
        chk("a_ready", a_ready, qa.size() < DEPTH);
        chk("b_ready", b_ready, qb.size() < DEPTH);
        chk("busy", busy, ha || hb);
        chk("write_e", rf_write_e, win != 0);
        chk("rf_rd", rf_rd, e.rd);
        chk("write_d", rf_write_d, e.data);
        chk("hazard_s1", hazard_s1, chk_s1 != 0 && pending(chk_s1));
        chk("hazard_s2", hazard_s2, chk_s2 != 0 && pending(chk_s2));
        if (win == 1) void'(qa.pop_front());
        if (win == 2) begin
          void'(qb.pop_front());
          if (ha) b_forced++;
        end
        if (hb && win == 1) losses++;
        else losses = 0;
      end
    end
  end

  // Stimulus: A uses odd registers, B uses even ones (including x0), so no rd is ever pending in both.
  initial begin
    bit fire_a, fire_b, hold_a, hold_b;
    int pa, pb, phase;
    hold_a = 0;
    hold_b = 0;
    for (int cyc = 0; cyc < 1700; cyc++) begin
      @(negedge clk);
      phase = (cyc - 4) / 400;
      rst = (cyc < 4) || (phase == 3 && cyc % 97 == 0);
      case (phase)
        0:       begin pa = 40;  pb = 0;  end
        1:       begin pa = 100; pb = 60; end
        2:       begin pa = 0;   pb = 70; end
        default: begin pa = 50;  pb = 50; end
      endcase
      if (cyc < 4) begin pa = 0; pb = 0; end
      if (!hold_a) begin
        a_valid = $urandom_range(0, 99) < pa;
        a_rd    = 5'(2 * $urandom_range(0, 3) + 1);
        a_data  = $urandom;
      end
      if (!hold_b) begin
        b_valid = $urandom_range(0, 99) < pb;
        b_rd    = 5'(2 * $urandom_range(0, 3));
        b_data  = $urandom;
      end
      chk_s1 = 5'($urandom_range(0, 7));
      chk_s2 = 5'($urandom_range(0, 7));
      #1;
      fire_a = a_valid && a_ready;
      fire_b = b_valid && b_ready;
      hold_a = a_valid && !fire_a;
      hold_b = b_valid && !fire_b;
      @(posedge clk);
      if (fire_a && a_rd != 0) begin
        foreach (qb[i]) if (qb[i].rd == a_rd) begin
          bad++;
          $display("FAIL contract: rd %0d pending on both ports", a_rd);
        end
        qa.push_back('{rd: a_rd, data: a_data});
      end
      if (fire_b && b_rd != 0) begin
        foreach (qa[i]) if (qa[i].rd == b_rd) begin
          bad++;
          $display("FAIL contract: rd %0d pending on both ports", b_rd);
        end
        qb.push_back('{rd: b_rd, data: b_data});
      end
    end
    @(negedge clk);
    rst     = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (20) @(negedge clk);
    #3;
    chk("drain_qa", qa.size(), 0);
    chk("drain_qb", qb.size(), 0);
    chk("drain_busy", busy, 0);
    if (b_forced == 0) begin
      bad++;
      $display("FAIL aging_seen: got %0d forced B grants want >0", b_forced);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
